pulse_sched: RTL
================

Name: pulse_sched

Overview:
- Source-domain (clka) scheduler that merges pulse requests from NREQ independent requesters onto the single `ina` line of the pulse-XOR synchronizer.
- The pulse-XOR synchronizer loses pulses spaced closer than about two clkb periods. This block queues each requester's pulses in a saturating pending counter.
- It grants requesters round-robin and issues one-cycle pulses no closer than GAP clka cycles apart.
- `pulse_id` tags each issued pulse so downstream logic can demux it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of `pulse_id`; must equal ceil(log2(NREQ)).
- GAP, 6, minimum clka cycles between rising edges of consecutive output pulses (≥2).
- CNTW, 4, pending-counter width per requester; saturates at 2^CNTW-1.

Ports:
- clka  in  1  source clock.
- rsta  in  1  asynchronous reset, active-high; clears all state immediately.
- req_pulse  in  NREQ  per-requester single-cycle request; each high cycle counts as one request.
- ovf_clr  in  1  clears all `ovf` bits at the next edge.
- pulse_out  out  1  registered single-cycle pulse; drives synchronizer `ina`.
- pulse_id  out  IDW  index of the requester served; valid while `pulse_out`=1, otherwise holds its last value.
- busy  out  1  high when any pending counter is nonzero or the FSM is not IDLE.
- ovf  out  NREQ  sticky per-requester flag; set when a request arrives at a saturated counter.

Behaviour:
- Reset (rsta=1, async):
  - `pulse_out`=0, `pulse_id`=0, `ovf`=0, `busy`=0.
  - All pending counters=0, round-robin pointer=0, FSM=IDLE, gap counter=0.
- Pending counter i, per edge:
  - +1 if req_pulse[i]=1.
  - −1 if requester i is granted this edge.
  - Both on the same edge: unchanged.
  - At max value with a request and no grant: unchanged, and ovf[i] set.
- Grant selection:
  - Candidates are requesters with pending>0, or with req_pulse=1 this cycle (bypass, so an idle request issues with 1-cycle latency).
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ. The first candidate wins.
  - After granting i, ptr=(i+1) mod NREQ.
- FSM:
  - IDLE: if any candidate exists, grant, then pulse_out=1 and pulse_id=winner at the next edge; go to GAPW with gap counter=GAP-1.
  - GAPW: pulse_out=0. Decrement the gap counter each edge; when it reaches 0, return to IDLE.
  - GAPW→IDLE takes 1 edge, and IDLE grants combinationally, so back-to-back pulses are exactly GAP cycles apart rising-edge to rising-edge.
  - Requests arriving during GAPW only increment counters.
- Latency: a request at edge t with FSM IDLE produces pulse_out=1 in cycle t+1, i.e. visible after edge t+1.
- `pulse_out` is never high for two consecutive cycles; the minimum low time is GAP-1 cycles.
- `busy`: registered, updated from next-state values (pending≠0 or FSM≠IDLE).
- `ovf`: ovf_clr has priority below a same-edge set, so a new overflow on the clearing edge remains set.
- Reset mid-gap or mid-pulse: pulse_out drops asynchronously and pending requests are discarded. No pulse is emitted until a new request arrives after rsta deasserts.
- Deassertion of rsta is assumed synchronized externally; the first edge after release behaves as IDLE.

Test Plan:
- Reset, then a single req_pulse[2] at edge 5 → pulse_out=1, pulse_id=2 in cycle 6; busy returns to 0 by cycle 6+GAP=12; no further pulses.
- req_pulse[0] high for 3 consecutive cycles → exactly 3 pulses, id=0, rising edges GAP=6 cycles apart; counter peaks at 2.
- req_pulse=4'b1111 for one cycle with ptr=0 → ids 0,1,2,3 in that order, spaced 6 cycles; next lone req on 1 granted only after ptr reaches it (ptr=0 → id 1).
- req_pulse[3] held 20 cycles (CNTW=4) → counter saturates at 15; ovf[3]=1; total pulses for id 3 = 15+issued-during-hold, exactly matching a reference model; ovf_clr clears it.
- rsta asserted mid-GAPW with pending counts 3/0/2/0 → pulse_out, busy, counters 0 immediately; after release, no pulse without new requests.
- Chain with the pulse-XOR synchronizer (clka 1ns, clkb 3ns), random requests over 500 cycles → count of outb pulses equals count of pulse_out pulses; none lost.

Source files
------------

// File: rtl/pulse_sched.sv
// Source-domain pulse scheduler: queues per-requester pulses in saturating counters and
// issues them round-robin onto a single line, spaced GAP cycles apart, tagged with pulse_id.
module pulse_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int GAP  = 6,
    parameter int CNTW = 4
) (
    input  logic            clka,
    input  logic            rsta,
    input  logic [NREQ-1:0] req_pulse,
    input  logic            ovf_clr,
    output logic            pulse_out,
    output logic [IDW-1:0]  pulse_id,
    output logic            busy,
    output logic [NREQ-1:0] ovf
);

    // GAP-1 always fits in clog2(GAP) bits because GAP >= 2
    localparam int              GW       = $clog2(GAP);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_GAPW  = 1'b1;
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP - 1);

    logic [CNTW-1:0] cnt_r [NREQ];
    logic [CNTW-1:0] cnt_s [NREQ];
    logic [IDW-1:0]  ptr_r;
    logic [0:0]      state_r, state_s;
    logic [GW-1:0]   gap_r, gap_s;
    logic            pulse_r;
    logic [IDW-1:0]  id_r, id_s;
    logic            busy_r, busy_s;
    logic [NREQ-1:0] ovf_r, ovf_s, ovf_set_s;
    logic [NREQ-1:0] cand_s;
    logic            found_s, grant_s, pend_any_s;
    logic [IDW-1:0]  win_s;

    assign pulse_out = pulse_r;
    assign pulse_id  = id_r;
    assign busy      = busy_r;
    assign ovf       = ovf_r;

    // Round-robin search from ptr over pending or bypassed requesters
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            cand_s[i] = req_pulse[i] | (cnt_r[i] != {CNTW{1'b0}});
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && cand_s[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                win_s   = IDW'((int'(ptr_r) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
        grant_s = (state_r == ST_IDLE) && found_s;
        id_s    = grant_s ? win_s : id_r;
    end

    // IDLE/GAPW sequencing; returning to IDLE on the last gap edge keeps pulses exactly GAP apart
    always_comb begin
        state_s = state_r;
        gap_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_GAPW;
                    gap_s   = GAP_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GAPW: begin
                if (gap_r <= GW'(1)) begin
                    state_s = ST_IDLE;
                    gap_s   = {GW{1'b0}};
                end else begin
                    gap_s   = gap_r - GW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gap_s   = {GW{1'b0}};
            end
        endcase
    end

    // Pending counters, sticky overflow flags and next-state busy
    always_comb begin
        ovf_set_s  = {NREQ{1'b0}};
        pend_any_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_s[i] = cnt_r[i];
            if (req_pulse[i] && !(grant_s && win_s == IDW'(i))) begin
                if (cnt_r[i] == CNT_MAX) begin
                    ovf_set_s[i] = 1'b1;
                end else begin
                    cnt_s[i] = cnt_r[i] + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end else if (!req_pulse[i] && grant_s && win_s == IDW'(i)) begin
                cnt_s[i] = cnt_r[i] - {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                cnt_s[i] = cnt_r[i];
            end
            pend_any_s = pend_any_s | (cnt_s[i] != {CNTW{1'b0}});
        end
        // a same-edge overflow survives the clear
        ovf_s  = ovf_set_s | (ovf_clr ? {NREQ{1'b0}} : ovf_r);
        busy_s = pend_any_s || (state_s != ST_IDLE);
    end

    // State registers
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_r[i] <= {CNTW{1'b0}};
            end
            ptr_r   <= {IDW{1'b0}};
            state_r <= ST_IDLE;
            gap_r   <= {GW{1'b0}};
            pulse_r <= 1'b0;
            id_r    <= {IDW{1'b0}};
            busy_r  <= 1'b0;
            ovf_r   <= {NREQ{1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
            if (grant_s) begin
                ptr_r <= IDW'((int'(win_s) + 1) % NREQ);
            end else begin
                ptr_r <= ptr_r;
            end
            state_r <= state_s;
            gap_r   <= gap_s;
            pulse_r <= grant_s;
            id_r    <= id_s;
            busy_r  <= busy_s;
            ovf_r   <= ovf_s;
        end
    end

endmodule
